// File: rtl/axi_write_responder_pkg.sv
// Shared types and helpers for the AXI3 write-channel responder.
package axi_write_responder_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Burst shape fields of an AW request. The id and address widths are
  // parameters of the top, so they are packed beside this struct in the queue.
  typedef struct packed {
    logic [3:0] len;
    logic [2:0] size;
    axi_burst_e burst;
  } aw_req_t;

  // Byte address of the next beat. Computed at 64 bits so any ADDR_W up to 64
  // can use it; the caller truncates to its own width.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [3:0]  len,
                                            input axi_burst_e  burst);
    logic [63:0] step;
    logic [63:0] mask;
    logic [63:0] nxt;
    step = 64'd1 << size;
    mask = (({60'd0, len} + 64'd1) << size) - 64'd1;
    nxt  = addr;
    case (burst)
      FIXED:   nxt = addr;
      INCR:    nxt = addr + step;
      WRAP:    nxt = (addr & ~mask) | ((addr + step) & mask);
      default: nxt = addr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_write_responder_sync_fifo.sv
// Small synchronous FIFO used for the AW request and B response queues.
// DEPTH must be a power of 2 and at least 2. A pop on a full queue frees
// the slot for a push in the same cycle; a pop on an empty queue is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Storage and pointer update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/axi_write_responder.sv
// AXI3 write-channel slave endpoint: queues AW requests, writes W beats of the
// queue head into a word memory, and returns in-order B responses with a
// configurable extra latency.
module axi_write_responder
  import axi_write_responder_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256,
  parameter int AW_DEPTH  = 4,
  parameter int B_DEPTH   = 4,
  parameter int B_LAT     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_rdata
);

  localparam int              BYTES     = DATA_W / 8;
  localparam int              OFF_W     = $clog2(BYTES);
  localparam int              IDX_W     = $clog2(MEM_WORDS);
  localparam int              REQ_W     = $bits(aw_req_t);
  localparam int              AW_W      = ID_W + ADDR_W + REQ_W;
  localparam int              B_W       = ID_W + 2;
  localparam logic [2:0]      SIZE_MAX  = 3'(OFF_W);
  localparam logic [3:0]      B_LAT_C   = 4'(B_LAT);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS * BYTES);

  // AW queue
  aw_req_t          aw_req_s;
  logic [AW_W-1:0]  aw_rdata_s;
  logic             aw_push_s;
  logic             aw_pop_s;
  logic             aw_full_s;
  logic             aw_empty_s;
  aw_req_t          head_req_s;
  logic [ID_W-1:0]  head_id_s;
  logic [ADDR_W-1:0] head_addr_s;

  // B queue
  logic [B_W-1:0]   b_rdata_s;
  logic             b_push_s;
  logic             b_pop_s;
  logic             b_full_s;
  logic             b_empty_s;

  // Burst state
  w_state_e         state_r;
  logic             wready_r;
  logic             rdy_r;
  logic [ID_W-1:0]  id_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]       len_r;
  logic [2:0]       size_r;
  axi_burst_e       burst_r;
  logic             bad_ctl_r;
  logic [4:0]       beat_cnt_r;
  logic             decerr_r;
  logic             slverr_r;
  logic [3:0]       lat_cnt_r;
  axi_resp_e        resp_r;

  // Per-beat decode
  logic             beat_s;
  logic             oor_s;
  logic             in_len_s;
  logic             id_mis_s;
  logic             mem_we_s;
  logic [IDX_W-1:0] word_idx_s;
  axi_resp_e        final_resp_s;

  logic [DATA_W-1:0] mem_r [MEM_WORDS];

  // Pack the incoming AW shape fields into the queue entry format.
  always_comb begin
    aw_req_s       = '{len: 4'd0, size: 3'd0, burst: FIXED};
    aw_req_s.len   = awlen;
    aw_req_s.size  = awsize;
    aw_req_s.burst = axi_burst_e'(awburst);
  end

  // awready is held low until the first clock after reset release.
  assign awready   = rdy_r && !aw_full_s;
  assign aw_push_s = awvalid && awready;

  assign head_id_s   = aw_rdata_s[AW_W-1 -: ID_W];
  assign head_addr_s = aw_rdata_s[REQ_W +: ADDR_W];
  assign head_req_s  = aw_req_t'(aw_rdata_s[REQ_W-1:0]);

  sync_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (aw_push_s),
    .wdata ({awid, awaddr, aw_req_s}),
    .pop   (aw_pop_s),
    .rdata (aw_rdata_s),
    .full  (aw_full_s),
    .empty (aw_empty_s)
  );

  assign wready     = wready_r;
  assign beat_s     = wvalid && wready_r;
  assign aw_pop_s   = beat_s && wlast;
  assign oor_s      = ({1'b0, addr_r} >= MEM_LIMIT);
  assign in_len_s   = !beat_cnt_r[4] && (beat_cnt_r[3:0] <= len_r);
  assign id_mis_s   = (wid != id_r);
  assign mem_we_s   = beat_s && !oor_s && !decerr_r && in_len_s && !bad_ctl_r;
  assign word_idx_s = IDX_W'(addr_r >> OFF_W);

  // Burst response on its wlast beat: DECERR beats SLVERR beats OKAY.
  always_comb begin
    final_resp_s = OKAY;
    if (decerr_r || oor_s) begin
      final_resp_s = DECERR;
    end else if (slverr_r || id_mis_s || bad_ctl_r || (beat_cnt_r != {1'b0, len_r})) begin
      final_resp_s = SLVERR;
    end else begin
      final_resp_s = OKAY;
    end
  end

  // The response leaves W_RESP once its latency has elapsed and the B queue has room.
  assign b_pop_s  = bready && !b_empty_s;
  assign b_push_s = (state_r == W_RESP) && (lat_cnt_r == B_LAT_C) && (!b_full_s || b_pop_s);

  sync_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (b_push_s),
    .wdata ({id_r, resp_r}),
    .pop   (b_pop_s),
    .rdata (b_rdata_s),
    .full  (b_full_s),
    .empty (b_empty_s)
  );

  assign bvalid = !b_empty_s;
  assign bid    = b_rdata_s[B_W-1:2];
  assign bresp  = b_rdata_s[1:0];

  // W burst FSM: load the AW head, accept its beats, then hand off the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= W_IDLE;
      wready_r   <= 1'b0;
      rdy_r      <= 1'b0;
      id_r       <= {ID_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      len_r      <= 4'd0;
      size_r     <= 3'd0;
      burst_r    <= FIXED;
      bad_ctl_r  <= 1'b0;
      beat_cnt_r <= 5'd0;
      decerr_r   <= 1'b0;
      slverr_r   <= 1'b0;
      lat_cnt_r  <= 4'd0;
      resp_r     <= OKAY;
    end else begin
      rdy_r <= 1'b1;
      case (state_r)
        W_IDLE: begin
          // Holding off while the B queue is full keeps wready low until it drains.
          if (!aw_empty_s && !b_full_s) begin
            id_r       <= head_id_s;
            addr_r     <= head_addr_s;
            len_r      <= head_req_s.len;
            size_r     <= head_req_s.size;
            burst_r    <= head_req_s.burst;
            bad_ctl_r  <= (head_req_s.burst == RSVD) || (head_req_s.size > SIZE_MAX);
            beat_cnt_r <= 5'd0;
            decerr_r   <= 1'b0;
            slverr_r   <= 1'b0;
            wready_r   <= 1'b1;
            state_r    <= W_DATA;
          end
        end
        W_DATA: begin
          if (beat_s) begin
            addr_r   <= ADDR_W'(next_addr(64'(addr_r), size_r, len_r, burst_r));
            decerr_r <= decerr_r || oor_s;
            slverr_r <= slverr_r || id_mis_s;
            // Saturate past len so an overlong burst can never alias a legal count.
            if (beat_cnt_r != 5'd16) begin
              beat_cnt_r <= beat_cnt_r + 5'd1;
            end
            if (wlast) begin
              resp_r    <= final_resp_s;
              lat_cnt_r <= 4'd0;
              wready_r  <= 1'b0;
              state_r   <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (lat_cnt_r != B_LAT_C) begin
            lat_cnt_r <= lat_cnt_r + 4'd1;
          end else if (b_push_s) begin
            state_r <= W_IDLE;
          end
        end
        default: begin
          wready_r <= 1'b0;
          state_r  <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-enabled memory write; the memory itself survives reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem_r[word_idx_s][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Backdoor read port; unmapped addresses read as zero.
  always_comb begin
    dbg_rdata = {DATA_W{1'b0}};
    if ({1'b0, dbg_addr} < MEM_LIMIT) begin
      dbg_rdata = mem_r[IDX_W'(dbg_addr >> OFF_W)];
    end else begin
      dbg_rdata = {DATA_W{1'b0}};
    end
  end

endmodule
